// File: rtl/point_cloud_stream_serializer_pkg.sv
// Shared constants, FSM state type and beat helpers for the point cloud
// stream serializer.
package pcs_pkg;

    localparam logic [15:0] HDR_MAGIC       = 16'hC10D;
    localparam int          BEAT_W          = 64;
    localparam int          BLOCK_W         = 512;
    localparam int          BEATS_PER_BLOCK = 8;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        WAIT
    } pcs_state_e;

    // Beat k of a block, most significant beat first.
    function automatic logic [BEAT_W-1:0] block_beat(input logic [BLOCK_W-1:0] blk,
                                                     input logic [2:0]         k);
        return blk[(BLOCK_W - 1) - BEAT_W * int'(k) -: BEAT_W];
    endfunction

    // Frame header: magic, sequence number, blocks per frame, reserved zero.
    function automatic logic [BEAT_W-1:0] header_beat(input logic [15:0] seq,
                                                      input logic [15:0] bpf);
        return {HDR_MAGIC, seq, bpf, 16'h0000};
    endfunction

endpackage

// File: rtl/point_cloud_stream_serializer_if.sv
// Block input (no backpressure) and 64-bit valid/ready output stream.
// slave is the serializer view, master the producer/sink view.
interface point_cloud_stream_serializer_if;
    import pcs_pkg::*;

    logic [BLOCK_W-1:0] in_data;
    logic               in_valid;
    logic [BEAT_W-1:0]  m_data;
    logic               m_valid;
    logic               m_ready;
    logic               m_last;

    modport master (
        output in_data, in_valid, m_ready,
        input  m_data, m_valid, m_last
    );

    modport slave (
        input  in_data, in_valid, m_ready,
        output m_data, m_valid, m_last
    );

endinterface

// File: rtl/sync_fifo_512.sv
// Synchronous FIFO of 512-bit blocks. Exposes the head entry and the entry
// behind it so the consumer can pre-load the next block's first beat on the
// same edge that pops the current one. No fall-through: a write becomes
// visible one cycle later.
module sync_fifo_512
    import pcs_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [BLOCK_W-1:0] wdata,
    input  logic               pop,
    output logic [BLOCK_W-1:0] head,
    output logic [BLOCK_W-1:0] head_next,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    logic [BLOCK_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_nxt;
    logic [CNT_W-1:0]   count_q;

    assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
    assign head       = mem_q[rd_ptr_q];
    assign head_next  = mem_q[rd_ptr_nxt];
    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;

    // Block storage; contents are don't-care until pointed at, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap freely.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_nxt;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/point_cloud_stream_serializer.sv
// Buffers 512-bit encrypted blocks and emits them as framed 64-bit beats:
// one header beat per BLOCKS_PER_FRAME blocks, then eight beats per block,
// m_last on the final beat of the frame. All stream outputs come from flops,
// so next-cycle beat contents are chosen in the next-state logic.
module point_cloud_stream_serializer
    import pcs_pkg::*;
#(
    parameter int FIFO_DEPTH       = 4,
    parameter int BLOCKS_PER_FRAME = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    point_cloud_stream_serializer_if.slave link,
    output logic                           overflow,
    output logic [15:0]                    frame_seq
);

    localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BPF_HDR   = 16'(BLOCKS_PER_FRAME);
    localparam logic [15:0] LAST_BLK  = 16'(BLOCKS_PER_FRAME - 1);
    localparam logic [2:0]  LAST_BEAT = 3'(BEATS_PER_BLOCK - 1);

    pcs_state_e         state_q,     state_d;
    logic [2:0]         beat_idx_q,  beat_idx_d;
    logic [15:0]        block_idx_q, block_idx_d;
    logic [15:0]        frame_seq_q, frame_seq_d;
    logic               overflow_q,  overflow_d;
    logic [BEAT_W-1:0]  m_data_q,    m_data_d;
    logic               m_valid_q,   m_valid_d;
    logic               m_last_q,    m_last_d;

    logic               accept;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [BLOCK_W-1:0] fifo_head;
    logic [BLOCK_W-1:0] fifo_head_next;

    sync_fifo_512 #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .wdata     (link.in_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .head_next (fifo_head_next),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign accept = m_valid_q && link.m_ready;

    // A full FIFO still takes a block when the head leaves on the same edge.
    assign fifo_push  = link.in_valid && (!fifo_full || fifo_pop);
    assign overflow_d = overflow_q || (link.in_valid && fifo_full && !fifo_pop);

    // Framing FSM and selection of the next registered beat.
    always_comb begin
        state_d     = state_q;
        beat_idx_d  = beat_idx_q;
        block_idx_d = block_idx_q;
        frame_seq_d = frame_seq_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        fifo_pop    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d   = HEADER;
                    m_valid_d = 1'b1;
                    m_data_d  = header_beat(frame_seq_q, BPF_HDR);
                    m_last_d  = 1'b0;
                end
            end
            HEADER: begin
                if (accept) begin
                    state_d    = PAYLOAD;
                    beat_idx_d = '0;
                    m_data_d   = block_beat(fifo_head, 3'd0);
                    m_last_d   = 1'b0;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (beat_idx_q != LAST_BEAT) begin
                        beat_idx_d = beat_idx_q + 3'd1;
                        m_data_d   = block_beat(fifo_head, beat_idx_d);
                        m_last_d   = (beat_idx_d == LAST_BEAT) && (block_idx_q == LAST_BLK);
                    end else begin
                        fifo_pop   = 1'b1;
                        beat_idx_d = '0;
                        m_last_d   = 1'b0;
                        if (block_idx_q == LAST_BLK) begin
                            frame_seq_d = frame_seq_q + 16'd1;
                            block_idx_d = '0;
                            state_d     = IDLE;
                            m_valid_d   = 1'b0;
                            m_data_d    = '0;
                        end else begin
                            block_idx_d = block_idx_q + 16'd1;
                            // Another stored block lets the next beat follow with no bubble.
                            if (fifo_count > CNT_W'(1)) begin
                                state_d  = PAYLOAD;
                                m_data_d = block_beat(fifo_head_next, 3'd0);
                            end else begin
                                state_d   = WAIT;
                                m_valid_d = 1'b0;
                                m_data_d  = '0;
                            end
                        end
                    end
                end
            end
            WAIT: begin
                if (!fifo_empty) begin
                    state_d   = PAYLOAD;
                    m_valid_d = 1'b1;
                    m_data_d  = block_beat(fifo_head, 3'd0);
                    m_last_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and registered stream outputs; reset abandons any frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            beat_idx_q  <= '0;
            block_idx_q <= '0;
            frame_seq_q <= '0;
            overflow_q  <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            beat_idx_q  <= beat_idx_d;
            block_idx_q <= block_idx_d;
            frame_seq_q <= frame_seq_d;
            overflow_q  <= overflow_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_data_q    <= m_data_d;
        end
    end

    assign link.m_data  = m_data_q;
    assign link.m_valid = m_valid_q;
    assign link.m_last  = m_last_q;
    assign overflow     = overflow_q;
    assign frame_seq    = frame_seq_q;

endmodule

// File: tb/tb_point_cloud_stream_serializer.sv
// Directed bench for point_cloud_stream_serializer (FIFO_DEPTH=4,
// BLOCKS_PER_FRAME=2): a cycle-exact vector table for the basic frame, then
// hand-written sequences for backpressure, overflow, full-with-pop,
// starvation, reset mid-frame and sequence wrap.
module tb_point_cloud_stream_serializer;
    import pcs_pkg::*;

    localparam int DEPTH = 4;
    localparam int BPF   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        overflow;
    logic [15:0] frame_seq;

    point_cloud_stream_serializer_if bus ();

    point_cloud_stream_serializer #(
        .FIFO_DEPTH       (DEPTH),
        .BLOCKS_PER_FRAME (BPF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .link      (bus.slave),
        .overflow  (overflow),
        .frame_seq (frame_seq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         in_valid;
        logic [511:0] in_data;
        logic         m_ready;
        logic         exp_valid;
        logic [63:0]  exp_data;
        logic         exp_last;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;

    vec_t  vecs [19];
    beat_t got_q [$];
    beat_t exp_q [$];

    // Distinct, tag- and position-dependent payload beats.
    function automatic logic [63:0] beat_val(input int tag, input int k);
        return {8'(tag), 8'(k), 48'hC0FF_EE12_3456 ^ 48'(tag * 977 + k * 31)};
    endfunction

    // Block whose beat 0 sits in the top 64 bits.
    function automatic logic [511:0] mk_block(input int tag);
        logic [511:0] b;
        b = '0;
        for (int k = 0; k < 8; k++) begin
            b = {b[447:0], beat_val(tag, k)};
        end
        return b;
    endfunction

    function automatic logic [63:0] hdr_val(input logic [15:0] seq);
        return {16'hC10D, seq, 16'h0002, 16'h0000};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int tag);
        bus.in_valid = 1'b1;
        bus.in_data  = mk_block(tag);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic exp_hdr(input logic [15:0] seq);
        beat_t b;
        b.data = hdr_val(seq);
        b.last = 1'b0;
        exp_q.push_back(b);
    endtask

    task automatic exp_blk(input int tag, input logic last_blk);
        beat_t b;
        for (int k = 0; k < 8; k++) begin
            b.data = beat_val(tag, k);
            b.last = last_blk && (k == 7);
            exp_q.push_back(b);
        end
    endtask

    task automatic start_stream();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic cmp_stream(input string name);
        chk({name, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_data%0d", name, i), got_q[i].data, exp_q[i].data);
            chk($sformatf("%s_last%0d", name, i), 64'(got_q[i].last), 64'(exp_q[i].last));
        end
    endtask

    task automatic wait_beat(input string name, input logic [63:0] val, input int budget);
        int n;
        n = 0;
        while (!(bus.m_valid === 1'b1 && bus.m_data === val) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: m_data %h never became %h within %0d cycles", name, bus.m_data, val, budget);
        end
    endtask

    // Records accepted beats and checks that a stalled beat holds steady.
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data  = '0;
    logic        prev_last  = 1'b0;
    always @(negedge clk) begin
        if (reset === 1'b1 && prev_stall) begin
            chk("stall_valid", 64'(bus.m_valid), 64'd1);
            chk("stall_data", bus.m_data, prev_data);
            chk("stall_last", 64'(bus.m_last), 64'(prev_last));
        end
        prev_stall = (reset === 1'b1) && bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
        prev_last  = bus.m_last;
        if (reset === 1'b1 && bus.m_valid && bus.m_ready) begin
            beat_t b;
            b.data = bus.m_data;
            b.last = bus.m_last;
            got_q.push_back(b);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rdy_pat;
        int         n;

        // Basic frame, one row per cycle, checked after each edge.
        for (int i = 0; i < 19; i++) begin
            vecs[i].in_valid  = 1'b0;
            vecs[i].in_data   = '0;
            vecs[i].m_ready   = 1'b1;
            vecs[i].exp_valid = 1'b1;
            vecs[i].exp_data  = '0;
            vecs[i].exp_last  = 1'b0;
        end
        vecs[0].in_valid  = 1'b1;
        vecs[0].in_data   = mk_block(1);
        vecs[0].exp_valid = 1'b0;
        vecs[1].in_valid  = 1'b1;
        vecs[1].in_data   = mk_block(2);
        vecs[1].exp_data  = hdr_val(16'h0000);
        for (int i = 2; i < 10; i++)  vecs[i].exp_data = beat_val(1, i - 2);
        for (int i = 10; i < 18; i++) vecs[i].exp_data = beat_val(2, i - 10);
        vecs[17].exp_last  = 1'b1;
        vecs[18].exp_valid = 1'b0;

        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.m_ready  = 1'b1;
        step();
        step();
        reset = 1'b1;

        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_m_last", 64'(bus.m_last), 64'd0);
        chk("rst_m_data", bus.m_data, 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_frame_seq", 64'(frame_seq), 64'd0);

        for (int i = 0; i < 19; i++) begin
            bus.in_valid = vecs[i].in_valid;
            bus.in_data  = vecs[i].in_data;
            bus.m_ready  = vecs[i].m_ready;
            step();
            chk($sformatf("vec%0d_valid", i), 64'(bus.m_valid), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_data", i), bus.m_data, vecs[i].exp_data);
                chk($sformatf("vec%0d_last", i), 64'(bus.m_last), 64'(vecs[i].exp_last));
            end
        end
        bus.in_valid = 1'b0;
        chk("vec_frame_seq", 64'(frame_seq), 64'd1);

        // Backpressure: same frame with m_ready cycling 1,0,0,1.
        reset = 1'b0;
        step();
        reset = 1'b1;
        start_stream();
        exp_hdr(16'h0000);
        exp_blk(1, 1'b0);
        exp_blk(2, 1'b1);
        bus.m_ready = 1'b1;
        send(1);
        send(2);
        rdy_pat = 4'b1001;
        for (int i = 0; i < 80; i++) begin
            bus.m_ready = rdy_pat[i % 4];
            step();
        end
        bus.m_ready = 1'b1;
        step();
        cmp_stream("bp");

        // Overflow: five blocks into a four-deep FIFO while the sink stalls.
        reset = 1'b0;
        step();
        reset = 1'b1;
        start_stream();
        bus.m_ready = 1'b0;
        send(11);
        send(12);
        send(13);
        send(14);
        chk("ovf_before", 64'(overflow), 64'd0);
        send(15);
        chk("ovf_after", 64'(overflow), 64'd1);
        exp_hdr(16'h0000);
        exp_blk(11, 1'b0);
        exp_blk(12, 1'b1);
        exp_hdr(16'h0001);
        exp_blk(13, 1'b0);
        exp_blk(14, 1'b1);
        bus.m_ready = 1'b1;
        repeat (60) step();
        cmp_stream("ovf");
        chk("ovf_sticky", 64'(overflow), 64'd1);
        chk("ovf_frame_seq", 64'(frame_seq), 64'd2);

        // Reset during beat 3: outputs clear, next frame restarts at seq 0.
        send(21);
        wait_beat("mid_beat3", beat_val(21, 3), 20);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("midrst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("midrst_m_last", 64'(bus.m_last), 64'd0);
        chk("midrst_m_data", bus.m_data, 64'd0);
        chk("midrst_overflow", 64'(overflow), 64'd0);
        chk("midrst_frame_seq", 64'(frame_seq), 64'd0);
        start_stream();
        exp_hdr(16'h0000);
        exp_blk(22, 1'b0);
        exp_blk(23, 1'b1);
        send(22);
        send(23);
        repeat (30) step();
        cmp_stream("after_rst");
        chk("after_rst_seq", 64'(frame_seq), 64'd1);

        // Sequence wrap: preload 16'hFFFF while idle.
        force dut.frame_seq_q = 16'hFFFF;
        step();
        release dut.frame_seq_q;
        step();
        chk("wrap_preload", 64'(frame_seq), 64'hFFFF);
        start_stream();
        exp_hdr(16'hFFFF);
        exp_blk(24, 1'b0);
        exp_blk(25, 1'b1);
        send(24);
        send(25);
        repeat (30) step();
        cmp_stream("wrap");
        chk("wrap_seq", 64'(frame_seq), 64'd0);
        start_stream();
        exp_hdr(16'h0000);
        exp_blk(26, 1'b0);
        exp_blk(27, 1'b1);
        send(26);
        send(27);
        repeat (30) step();
        cmp_stream("wrap_next");

        // Full FIFO with a write on the edge that pops: nothing dropped.
        reset = 1'b0;
        step();
        reset = 1'b1;
        start_stream();
        bus.m_ready = 1'b0;
        send(31);
        send(32);
        send(33);
        send(34);
        bus.m_ready = 1'b1;
        n = 0;
        while (!(bus.m_valid === 1'b1 && bus.m_data === beat_val(31, 7)) && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL fullpop_wait: m_data %h never became %h", bus.m_data, beat_val(31, 7));
        end
        bus.in_valid = 1'b1;
        bus.in_data  = mk_block(35);
        step();
        bus.in_valid = 1'b0;
        chk("fullpop_ovf", 64'(overflow), 64'd0);
        exp_hdr(16'h0000);
        exp_blk(31, 1'b0);
        exp_blk(32, 1'b1);
        exp_hdr(16'h0001);
        exp_blk(33, 1'b0);
        exp_blk(34, 1'b1);
        exp_hdr(16'h0002);
        exp_blk(35, 1'b0);
        repeat (80) step();
        cmp_stream("fullpop");
        chk("fullpop_ovf_end", 64'(overflow), 64'd0);

        // Starvation mid-frame: second block arrives 20 cycles after the first.
        reset = 1'b0;
        step();
        reset = 1'b1;
        start_stream();
        bus.m_ready = 1'b1;
        send(41);
        repeat (19) step();
        chk("starve_wait_valid", 64'(bus.m_valid), 64'd0);
        chk("starve_beats_so_far", 64'(got_q.size()), 64'd9);
        send(42);
        repeat (20) step();
        exp_hdr(16'h0000);
        exp_blk(41, 1'b0);
        exp_blk(42, 1'b1);
        cmp_stream("starve");
        chk("starve_seq", 64'(frame_seq), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
